// File: rtl/scoreboard_ctrl.sv
// Purpose : register scoreboard and issue/stall/drain controller for a decode stage.
// Latency : issue/stall/drain_done are combinational; busy_map, counters, timeout update one cycle later.
// Backpressure: decode is held (stall) on RAW/WAW hazards and while draining; nothing is dropped.
//
// Ports
//   clk_i, rst_ni        single rising-edge clock, synchronous active-low reset
//   dec_*_i              decode-stage instruction: valid, sources (rs/rt + use bits),
//                        destination (rd + reg_wr)
//   wb_reg_wr_i/wb_dir_wr_i  writeback commit strobe and register address
//   drain_req_i          level request to let the pipeline empty
//   issue_o / stall_o    decode advances / decode must hold this cycle
//   drain_done_o         single-cycle pulse once every pending write has retired
//   busy_map_o           registered pending-write bit per register (bit 0 always 0)
//   stall_count_o        saturating count of all stall cycles
//   timeout_o            sticky flag: TIMEOUT consecutive stall cycles were seen
//
// Build option
//   SCOREBOARD_WB_BYPASS_EN  when defined, a register being written back this
//                            cycle is treated as not pending by the hazard check
//                            (register file write-through). Default: undefined.

module scoreboard_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   dec_valid_i,
    input  logic [ADDR_W-1:0]      dec_rs_i,
    input  logic [ADDR_W-1:0]      dec_rt_i,
    input  logic                   dec_use_rs_i,
    input  logic                   dec_use_rt_i,
    input  logic [ADDR_W-1:0]      dec_rd_i,
    input  logic                   dec_reg_wr_i,
    input  logic                   wb_reg_wr_i,
    input  logic [ADDR_W-1:0]      wb_dir_wr_i,
    input  logic                   drain_req_i,
    output logic                   issue_o,
    output logic                   stall_o,
    output logic                   drain_done_o,
    output logic [(2**ADDR_W)-1:0] busy_map_o,
    output logic [CNT_W-1:0]       stall_count_o,
    output logic                   timeout_o
);

    localparam int NREG  = 2**ADDR_W;
    // Wide enough to hold TIMEOUT itself; the run counter saturates there.
    localparam int RUN_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [NREG-1:0]  REG0_BIT  = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [RUN_W:0]   RUN_ONE   = {{RUN_W{1'b0}}, 1'b1};
    localparam logic [RUN_W:0]   RUN_LIMIT = (RUN_W+1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   busy_eff;
    logic [NREG-1:0]   rd_oh, wb_oh;
    logic              pulsed_q, pulsed_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [RUN_W:0]    run_inc;
    logic              timeout_q, timeout_d;

    logic              rs_haz, rt_haz, waw_haz, hazard;
    logic              all_clear;
    logic              issue, stall, drain_done;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign rd_oh = REG0_BIT << dec_rd_i;
    assign wb_oh = REG0_BIT << wb_dir_wr_i;

`ifdef SCOREBOARD_WB_BYPASS_EN
    // The register file writes through, so a write retiring this cycle
    // already satisfies any reader or writer in decode.
    assign busy_eff = busy_q & ~(wb_oh & {NREG{wb_reg_wr_i}});
`else
    // Clearance becomes visible only once busy_q has been updated.
    assign busy_eff = busy_q;
`endif

    // busy_q[0] is held at zero, so register 0 can never raise a hazard.
    assign rs_haz  = dec_use_rs_i & busy_eff[dec_rs_i];
    assign rt_haz  = dec_use_rt_i & busy_eff[dec_rt_i];
    assign waw_haz = dec_reg_wr_i & busy_eff[dec_rd_i];
    assign hazard  = dec_valid_i & (rs_haz | rt_haz | waw_haz);

    // Drain completion looks at the registered map: every write issued
    // before the drain started must have been committed.
    assign all_clear = ~|busy_q;

    // ------------------------------------------------------------------
    // Control FSM: next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        stall      = 1'b0;
        drain_done = 1'b0;

        unique case (state_q)
            // RUN and STALL share their output rules; STALL just records
            // that the instruction in decode is being held.
            S_RUN, S_STALL: begin
                issue = dec_valid_i & ~hazard & ~drain_req_i;
                stall = hazard;
                if (drain_req_i) begin
                    state_d = S_DRAIN;
                end else if (hazard) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                stall = dec_valid_i;
                if (all_clear) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                stall = dec_valid_i;
                // Pulse only on the first cycle in DONE; holding drain_req
                // keeps the FSM here without pulsing again.
                drain_done = ~pulsed_q;
                if (!drain_req_i) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        // Outputs are quiet while reset is being applied.
        if (!rst_ni) begin
            issue      = 1'b0;
            stall      = 1'b0;
            drain_done = 1'b0;
        end
    end

    assign pulsed_d = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Scoreboard update: writeback clears, issue sets; a set to the same
    // register in the same cycle wins because it is applied last.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wb_reg_wr_i) begin
            busy_d = busy_d & ~wb_oh;
        end
        if (issue && dec_reg_wr_i) begin
            busy_d = busy_d | rd_oh;
        end
        busy_d = busy_d & ~REG0_BIT;
    end

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        run_d       = '0;
        timeout_d   = timeout_q;
        run_inc     = {1'b0, run_q} + RUN_ONE;
        if (stall) begin
            if (!(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            // run_inc is the length of the current stall run including
            // this cycle; the flag rises on the edge that completes
            // TIMEOUT consecutive stall cycles.
            if (run_inc >= RUN_LIMIT) begin
                run_d     = RUN_LIMIT[RUN_W-1:0];
                timeout_d = 1'b1;
            end else begin
                run_d = run_inc[RUN_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            busy_q      <= '0;
            pulsed_q    <= 1'b0;
            stall_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pulsed_q    <= pulsed_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign issue_o       = issue;
    assign stall_o       = stall;
    assign drain_done_o  = drain_done;
    assign busy_map_o    = busy_q;
    assign stall_count_o = stall_cnt_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Bench for scoreboard_ctrl (default build, write-through bypass disabled).
// Directed vector table, hand-written drain/timeout/reset sequences, then
// randomized traffic against a behavioural model of the scoreboard rules.

module tb_scoreboard_ctrl;

    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 255;
    localparam int NREG    = 32;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dec_valid, dec_use_rs, dec_use_rt, dec_reg_wr;
    logic              wb_reg_wr, drain_req;
    logic [ADDR_W-1:0] dec_rs, dec_rt, dec_rd, wb_dir_wr;
    logic              issue, stall, drain_done, timeout;
    logic [NREG-1:0]   busy_map;
    logic [CNT_W-1:0]  stall_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scoreboard_ctrl #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .dec_valid_i  (dec_valid),
        .dec_rs_i     (dec_rs),
        .dec_rt_i     (dec_rt),
        .dec_use_rs_i (dec_use_rs),
        .dec_use_rt_i (dec_use_rt),
        .dec_rd_i     (dec_rd),
        .dec_reg_wr_i (dec_reg_wr),
        .wb_reg_wr_i  (wb_reg_wr),
        .wb_dir_wr_i  (wb_dir_wr),
        .drain_req_i  (drain_req),
        .issue_o      (issue),
        .stall_o      (stall),
        .drain_done_o (drain_done),
        .busy_map_o   (busy_map),
        .stall_count_o(stall_count),
        .timeout_o    (timeout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic wr,
                       input logic wbv, input logic [4:0] wba, input logic dr);
        dec_valid  = v;
        dec_rs     = rs;
        dec_use_rs = urs;
        dec_rt     = rt;
        dec_use_rt = urt;
        dec_rd     = rd;
        dec_reg_wr = wr;
        wb_reg_wr  = wbv;
        wb_dir_wr  = wba;
        drain_req  = dr;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] rd;
        logic       wr;
        logic       wbv;
        logic [4:0] wba;
        logic       dr;
        logic       e_issue;
        logic       e_stall;
        logic       e_done;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt,
                                input logic [4:0] rd, input logic wr,
                                input logic wbv, input logic [4:0] wba, input logic dr,
                                input logic ei, input logic es, input logic ed,
                                input logic [31:0] eb);
        vec_t r;
        r.v = v; r.rs = rs; r.urs = urs; r.rt = rt; r.urt = urt;
        r.rd = rd; r.wr = wr; r.wbv = wbv; r.wba = wba; r.dr = dr;
        r.e_issue = ei; r.e_stall = es; r.e_done = ed; r.e_busy = eb;
        return r;
    endfunction

    vec_t tbl[17];

    // ------------------------------------------------------------------
    // Behavioural model: a set of pending registers plus a drain phase
    // ------------------------------------------------------------------
    bit m_pend[NREG];
    int m_phase;     // 0 normal operation, 1 waiting for writes to retire, 2 drain finished
    bit m_pulsed;
    int m_stalls;
    int m_run;
    bit m_to;
    bit e_issue, e_stall, e_done;

    function automatic bit m_pending(input logic [ADDR_W-1:0] a);
        return (a != 0) && m_pend[a];
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_phase  = 0;
        m_pulsed = 1'b0;
        m_stalls = 0;
        m_run    = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_eval();
        bit haz;
        haz = dec_valid && ((dec_use_rs && m_pending(dec_rs)) ||
                            (dec_use_rt && m_pending(dec_rt)) ||
                            (dec_reg_wr && m_pending(dec_rd)));
        e_issue = 1'b0;
        e_stall = 1'b0;
        e_done  = 1'b0;
        if (!rst_n) return;
        if (m_phase == 0) begin
            e_issue = dec_valid && !haz && !drain_req;
            e_stall = haz;
        end else if (m_phase == 1) begin
            e_stall = dec_valid;
        end else begin
            e_stall = dec_valid;
            e_done  = !m_pulsed;
        end
    endtask

    task automatic model_step();
        bit empty;
        if (!rst_n) begin
            model_reset();
            return;
        end
        empty = 1'b1;
        foreach (m_pend[i]) if (m_pend[i]) empty = 1'b0;
        if (wb_reg_wr) m_pend[wb_dir_wr] = 1'b0;
        if (e_issue && dec_reg_wr && dec_rd != 0) m_pend[dec_rd] = 1'b1;
        if (e_stall) begin
            if (m_stalls < SAT) m_stalls++;
            m_run++;
            if (m_run >= TIMEOUT) m_to = 1'b1;
        end else begin
            m_run = 0;
        end
        if (m_phase == 0) begin
            if (drain_req) m_phase = 1;
        end else if (m_phase == 1) begin
            if (empty) begin
                m_phase  = 2;
                m_pulsed = 1'b0;
            end
        end else begin
            m_pulsed = 1'b1;
            if (!drain_req) m_phase = 0;
        end
    endtask

    function automatic logic [NREG-1:0] model_map();
        logic [NREG-1:0] mb;
        foreach (m_pend[i]) mb[i] = m_pend[i];
        return mb;
    endfunction

    initial begin
        int drain_left;

        // Expected values assume a clean RUN state and empty map at row 0.
        tbl[0]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        tbl[1]  = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
        tbl[2]  = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0020);
        tbl[3]  = mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        tbl[4]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        tbl[5]  = mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        tbl[6]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        tbl[7]  = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_00C0);
        tbl[8]  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0080);
        tbl[9]  = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0080);
        tbl[10] = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        tbl[11] = mk(1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200);
        tbl[12] = mk(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
        tbl[13] = mk(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
        tbl[14] = mk(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        tbl[15] = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        tbl[16] = mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

        // ---------------- reset behaviour ----------------
        rst_n = 1'b0;
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("rst_issue", issue, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_done", drain_done, 1'b0);
        cyc();
        cyc();
        chk("rst_busy", busy_map, 32'h0);
        chk("rst_count", stall_count, 16'd0);
        chk("rst_timeout", timeout, 1'b0);
        rst_n = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < 17; i++) begin
            drv(tbl[i].v, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
                tbl[i].rd, tbl[i].wr, tbl[i].wbv, tbl[i].wba, tbl[i].dr);
            @(negedge clk);
            chk($sformatf("vec%0d_issue", i), issue, tbl[i].e_issue);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
            chk($sformatf("vec%0d_done", i), drain_done, tbl[i].e_done);
            chk($sformatf("vec%0d_busy", i), busy_map, tbl[i].e_busy);
            cyc();
        end

        // ---------------- drain with r3, r4 pending ----------------
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0); cyc();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0); cyc();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("drn_busy", busy_map, 32'h18);
        chk("drn_req_issue", issue, 1'b0);
        cyc();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1);
        @(negedge clk);
        chk("drn_hold_issue", issue, 1'b0);
        chk("drn_hold_stall", stall, 1'b1);
        chk("drn_wb3_done", drain_done, 1'b0);
        cyc();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
        @(negedge clk);
        chk("drn_wb4_busy", busy_map, 32'h10);
        chk("drn_wb4_done", drain_done, 1'b0);
        cyc();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        chk("drn_empty_done", drain_done, 1'b0);
        chk("drn_empty_busy", busy_map, 32'h0);
        cyc();
        @(negedge clk);
        chk("drn_pulse", drain_done, 1'b1);
        chk("drn_pulse_issue", issue, 1'b0);
        cyc();
        @(negedge clk);
        chk("drn_no_repulse", drain_done, 1'b0);
        cyc();
        drain_req = 1'b0;
        @(negedge clk);
        chk("drn_release_done", drain_done, 1'b0);
        chk("drn_release_issue", issue, 1'b0);
        cyc();
        @(negedge clk);
        chk("drn_resume_issue", issue, 1'b1);
        chk("drn_resume_done", drain_done, 1'b0);
        cyc();

        // ---------------- timeout over a 300-cycle stall ----------------
        rst_n = 1'b0; idle(); cyc(); rst_n = 1'b1;
        chk("to_cnt_clear", stall_count, 16'd0);
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0); cyc();
        drv(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        chk("to_stall", stall, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            cyc();
            if (k == 254) begin
                chk("to_before", timeout, 1'b0);
                chk("to_cnt254", stall_count, 16'd254);
            end
            if (k == 255) chk("to_at255", timeout, 1'b1);
        end
        chk("to_cnt300", stall_count, 16'd300);
        chk("to_busy", busy_map, 32'h4);
        chk("to_still_stall", stall, 1'b1);
        dec_valid = 1'b0;
        cyc();
        cyc();
        chk("to_sticky", timeout, 1'b1);
        chk("to_cnt_hold", stall_count, 16'd300);

        // ---------------- reset in STALL with busy nonzero ----------------
        drv(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
        cyc();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rs_gate_stall", stall, 1'b0);
        chk("rs_gate_issue", issue, 1'b0);
        cyc();
        chk("rs_busy", busy_map, 32'h0);
        chk("rs_count", stall_count, 16'd0);
        chk("rs_timeout", timeout, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_run_issue", issue, 1'b1);
        chk("rs_run_stall", stall, 1'b0);
        cyc();

        // ---------------- reset in DRAIN: no completion pulse ----------------
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0); cyc();
        chk("rd_busy", busy_map, 32'h8);
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1); cyc();
        rst_n = 1'b0; idle(); cyc(); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rd_nopulse%0d", k), drain_done, 1'b0);
            cyc();
        end
        chk("rd_busy_clear", busy_map, 32'h0);

        // ---------------- randomized traffic vs model ----------------
        rst_n = 1'b0; idle(); cyc(); model_reset(); rst_n = 1'b1;
        drain_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            dec_valid  = ($urandom_range(0, 9) < 8);
            dec_rs     = 5'($urandom_range(0, 7));
            dec_rt     = 5'($urandom_range(0, 7));
            dec_rd     = 5'($urandom_range(0, 7));
            dec_use_rs = 1'($urandom_range(0, 1));
            dec_use_rt = 1'($urandom_range(0, 1));
            dec_reg_wr = ($urandom_range(0, 9) < 6);
            wb_reg_wr  = ($urandom_range(0, 9) < 4);
            wb_dir_wr  = 5'($urandom_range(0, 7));
            if (drain_left == 0 && $urandom_range(0, 99) < 3) drain_left = $urandom_range(1, 12);
            drain_req = (drain_left != 0);
            if (drain_left != 0) drain_left--;
            model_eval();
            @(negedge clk);
            chk("rnd_issue", issue, e_issue);
            chk("rnd_stall", stall, e_stall);
            chk("rnd_done", drain_done, e_done);
            chk("rnd_busy", busy_map, model_map());
            chk("rnd_count", stall_count, 64'(m_stalls));
            chk("rnd_timeout", timeout, m_to);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scoreboard_ctrl.md
SCOREBOARD_CTRL -- requirements
Module: scoreboard_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, register address width (2^ADDR_W registers).
REQ-002 Parameter CNT_W, default 16, stall counter width.
REQ-003 Parameter TIMEOUT, default 255, consecutive stall cycles before timeout flags.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 dec_valid  input  1  decode holds an instruction.
REQ-007 dec_rs, dec_rt  input  ADDR_W each  source register addresses.
REQ-008 dec_use_rs, dec_use_rt  input  1 each  source actually read.
REQ-009 dec_rd  input  ADDR_W  destination address.
REQ-010 dec_reg_wr  input  1  instruction writes dec_rd.
REQ-011 wb_reg_wr  input  1  writeback commits this cycle.
REQ-012 wb_dir_wr  input  ADDR_W  writeback address.
REQ-013 drain_req  input  1  request to empty pipeline (level).
REQ-014 issue  output  1  decode instruction advances this cycle.
REQ-015 stall  output  1  decode must hold.
REQ-016 drain_done  output  1  one-cycle pulse: drain complete.
REQ-017 busy_map  output  2^ADDR_W  pending-write bit per register.
REQ-018 stall_count  output  CNT_W  saturating total stall cycles.
REQ-019 timeout  output  1  sticky: stall exceeded TIMEOUT.

Function
REQ-020 Hazard = dec_valid AND (rs hazard OR rt hazard OR WAW: dec_reg_wr and busy_map[dec_rd]); rs hazard = dec_use_rs and busy_map[dec_rs]; rt likewise.
REQ-021 Register 0 never pending: busy_map[0] SHALL read 0 always; address 0 never causes hazard.
REQ-022 States: RUN, STALL, DRAIN, DONE.
REQ-023 RUN: issue = dec_valid and no hazard and drain_req low; stall = dec_valid and hazard; hazard -> STALL; drain_req -> DRAIN.
REQ-024 STALL: issue = 0 while hazard persists; on hazard clearing, issue = 1 that cycle and next state RUN; drain_req -> DRAIN (takes priority).
REQ-025 DRAIN: issue = 0, stall = dec_valid; when busy_map all zero -> DONE.
REQ-026 DONE: drain_done = 1 for exactly one cycle; then RUN if drain_req low, else remain DONE without re-pulsing.
REQ-027 Issue sets busy_map[dec_rd] next cycle when dec_reg_wr and dec_rd != 0.
REQ-028 wb_reg_wr clears busy_map[wb_dir_wr] next cycle.
REQ-029 Same-cycle issue set and WB clear on same address: set wins.
REQ-030 Outputs issue, stall and drain_done are combinational from state and inputs; busy_map is registered.
REQ-031 stall_count increments each cycle stall = 1, saturating at all-ones.
REQ-032 Internal run counter counts consecutive stall cycles, zeroed when stall = 0; when it reaches TIMEOUT, timeout sets and remains set until reset.
REQ-033 WB to a register not pending is legal and has no effect.

Reset
REQ-034 With rst low at a rising edge: state RUN, busy_map 0, stall_count 0, run counter 0, timeout 0; issue/stall/drain_done 0 during reset.
REQ-035 Reset mid-stall or mid-drain abandons the operation; no drain_done pulse.

Configuration
REQ-036 Macro SCOREBOARD_WB_BYPASS_EN defined: a source or destination matching wb_dir_wr with wb_reg_wr = 1 is treated as not pending in the same cycle (register file write-through).
REQ-037 Macro undefined: hazard check uses registered busy_map only; clearance visible one cycle after WB.

Verification
REQ-038 Issue rd=5 wr, next cycle rs=5 use_rs -> stall=1, busy_map[5]=1; WB dir=5 -> issue one cycle later (bypass undefined) or same cycle (defined).
REQ-039 Issue rd=0 dec_reg_wr=1, next instr rs=0 -> no stall, busy_map=0.
REQ-040 Same cycle issue rd=7 and WB dir=7 -> busy_map[7]=1 afterwards.
REQ-041 Pending r3,r4; drain_req=1 -> issue=0; WB r3, WB r4 -> DONE, drain_done high exactly one cycle.
REQ-042 Hold hazard 300 cycles, TIMEOUT=255 -> timeout set at stall cycle 255, stays set; stall_count=300.
REQ-043 Reset asserted during STALL with busy_map nonzero -> all outputs and busy_map zero next cycle, state RUN.
